// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx front-end.
// Arbiter state encoding, parity codes, reset baud divisor.
package uart_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_ODD  = 2'b01,
      PAR_EVEN = 2'b10,
      PAR_RSVD = 2'b11
   } parity_e;

   localparam logic [15:0] RST_BAUD_DEF = 16'd900;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: first valid index after last_i, wrapping.
// Purely combinational.
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] valid_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   logic [W-1:0] cand;

   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      cand    = last_i;
      for (int i = 0; i < N; i++) begin
         cand = (cand == W'(N - 1)) ? '0 : cand + 1'b1;
         if (!found_o && valid_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin byte arbiter and line-config front-end for uart_tx.
// Config outputs only move on IDLE edges so a frame keeps its settings.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int               N_REQ    = 4,
   parameter int               TMO_W    = 20,
   parameter logic [TMO_W-1:0] DONE_TMO = 20'hFFFFF,
   parameter logic [15:0]      RST_BAUD = RST_BAUD_DEF
) (
   input  logic                       mclk,
   input  logic                       n_reset,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [8*N_REQ-1:0]         req_data,
   output logic [N_REQ-1:0]           req_ready,
   input  logic                       cfg_wr,
   input  logic [15:0]                cfg_baudrate,
   input  logic [1:0]                 cfg_parity_sel,
   input  logic                       cfg_stop_sel,
   output logic [15:0]                baudrate,
   output logic [1:0]                 parity_sel,
   output logic                       stop_sel,
   output logic [7:0]                 tdata,
   output logic                       send_en,
   input  logic                       done,
   output logic                       busy,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       tmo_err
);

   localparam int GW = $clog2(N_REQ);

   state_e             state_q, state_d;
   logic [TMO_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         tdata_q, tdata_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [N_REQ-1:0]   ready_q, ready_d;
   logic               send_q, send_d;
   logic               tmo_q, tmo_d;
   logic [15:0]        baud_q, baud_d, sh_baud_q, sh_baud_d;
   logic [1:0]         par_q, par_d, sh_par_q, sh_par_d;
   logic               stop_q, stop_d, sh_stop_q, sh_stop_d;

   logic [GW-1:0]      pick;
   logic               found;
   logic [7:0]         bytes [N_REQ];
   logic [TMO_W-1:0]   cnt_inc;

   rr_pick #(.N(N_REQ), .W(GW)) u_pick (
      .valid_i (req_valid),
      .last_i  (grant_q),
      .idx_o   (pick),
      .found_o (found)
   );

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         bytes[i] = req_data[8*i +: 8];
      end
   end

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tdata_d   = tdata_q;
      grant_d   = grant_q;
      ready_d   = '0;
      send_d    = 1'b0;
      tmo_d     = 1'b0;
      baud_d    = baud_q;
      par_d     = par_q;
      stop_d    = stop_q;
      sh_baud_d = cfg_wr ? cfg_baudrate   : sh_baud_q;
      sh_par_d  = cfg_wr ? cfg_parity_sel : sh_par_q;
      sh_stop_d = cfg_wr ? cfg_stop_sel   : sh_stop_q;
      unique case (state_q)
         ST_IDLE: begin
            // Write-through so a cfg_wr on the launch edge hits this frame
            baud_d = sh_baud_d;
            par_d  = sh_par_d;
            stop_d = sh_stop_d;
            if (found) begin
               tdata_d       = bytes[pick];
               grant_d       = pick;
               ready_d[pick] = 1'b1;
               send_d        = 1'b1;
               cnt_d         = '0;
               state_d       = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (done) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_inc == DONE_TMO) begin
               tmo_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge mclk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         tdata_q   <= '0;
         grant_q   <= GW'(N_REQ - 1);
         ready_q   <= '0;
         send_q    <= 1'b0;
         tmo_q     <= 1'b0;
         baud_q    <= RST_BAUD;
         par_q     <= PAR_NONE;
         stop_q    <= 1'b0;
         sh_baud_q <= RST_BAUD;
         sh_par_q  <= PAR_NONE;
         sh_stop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tdata_q   <= tdata_d;
         grant_q   <= grant_d;
         ready_q   <= ready_d;
         send_q    <= send_d;
         tmo_q     <= tmo_d;
         baud_q    <= baud_d;
         par_q     <= par_d;
         stop_q    <= stop_d;
         sh_baud_q <= sh_baud_d;
         sh_par_q  <= sh_par_d;
         sh_stop_q <= sh_stop_d;
      end
   end

   assign req_ready  = ready_q;
   assign send_en    = send_q;
   assign tdata      = tdata_q;
   assign busy       = (state_q == ST_WAIT);
   assign grant_id   = grant_q;
   assign tmo_err    = tmo_q;
   assign baudrate   = baud_q;
   assign parity_sel = par_q;
   assign stop_sel   = stop_q;

endmodule
